axi_slave_mem: RTL and testbench

AXI4 subordinate (slave-side responder) that terminates one AXI port in a byte-addressable on-chip memory model. It sits where the VIP's master drives traffic and serves as the default downstream responder in block-level benches. It accepts AW/W bursts and returns B, and accepts AR and returns R bursts. Read and write paths are independent, each with one outstanding burst.

---
 rtl/axi_slave_mem.sv | 212 +++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 subordinate backed by a byte-addressable on-chip memory.
// Independent read and write FSMs, one outstanding burst each, all outputs registered.
module axi_slave_mem #(
   parameter int ID_WIDTH   = 16,
   parameter int ADDR_WIDTH = 64,
   parameter int BYTE_WIDTH = 32,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [BYTE_WIDTH*8-1:0] wdata,
   input  logic [BYTE_WIDTH-1:0]   wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [BYTE_WIDTH*8-1:0] rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int LOG_BW = $clog2(BYTE_WIDTH);
   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int DATA_W = BYTE_WIDTH * 8;
   localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] OKAY   = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[LOG_BW +: IDX_W];
   endfunction

   function automatic logic proto_err(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      return (burst == 2'b11) || (int'(size) > LOG_BW) ||
             ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   // WRAP keeps the bits above the wrap block and takes the low bits from the INCR step.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] incr, step, wmask;
      incr  = A_ONE << size;
      step  = (a & ~(incr - A_ONE)) + incr;
      wmask = ((ADDR_WIDTH'(len) + A_ONE) << size) - A_ONE;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~wmask) | (step & wmask);
         default: return step;
      endcase
   endfunction

   // ---------------- write path ----------------
   wstate_t               wstate, wnext;
   logic [ID_WIDTH-1:0]   wid;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [7:0]            wlen, wcnt;
   logic [2:0]            wsize;
   logic [1:0]            wburst;
   logic                  werr, wlast_err, w_hs, w_final;

   always_comb begin
      w_hs    = (wstate == W_DATA) && wvalid && wready;
      w_final = (wcnt == wlen);
      wnext   = wstate;
      case (wstate)
         W_IDLE:  if (awvalid && awready) wnext = W_DATA;
         W_DATA:  if (w_hs && w_final) wnext = W_RESP;
         W_RESP:  if (bvalid && bready) wnext = W_IDLE;
         default: wnext = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate    <= W_IDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
         wid       <= '0;
         waddr     <= '0;
         wlen      <= '0;
         wcnt      <= '0;
         wsize     <= '0;
         wburst    <= '0;
         werr      <= 1'b0;
         wlast_err <= 1'b0;
      end else begin
         wstate  <= wnext;
         awready <= (wnext == W_IDLE);
         wready  <= (wnext == W_DATA);
         bvalid  <= (wnext == W_RESP);
         if (wstate == W_IDLE && awvalid && awready) begin
            wid       <= awid;
            waddr     <= awaddr;
            wlen      <= awlen;
            wsize     <= awsize;
            wburst    <= awburst;
            wcnt      <= '0;
            werr      <= proto_err(awlen, awsize, awburst);
            wlast_err <= 1'b0;
         end
         if (w_hs) begin
            waddr <= next_addr(waddr, wlen, wsize, wburst);
            wcnt  <= wcnt + 8'd1;
            if (wlast != w_final) wlast_err <= 1'b1;
            if (w_final) begin
               bid   <= wid;
               bresp <= (werr || wlast_err || (wlast != w_final)) ? SLVERR : OKAY;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_hs && !werr) begin
         for (int unsigned b = 0; b < BYTE_WIDTH; b++) begin
            if (wstrb[b]) mem[word_idx(waddr)][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   rstate_t               rstate, rnext;
   logic [ADDR_WIDTH-1:0] raddr, r_step;
   logic [7:0]            rlen, rcnt;
   logic [2:0]            rsize;
   logic [1:0]            rburst;
   logic                  rerr, ar_hs, r_hs;

   always_comb begin
      ar_hs  = (rstate == R_IDLE) && arvalid && arready;
      r_hs   = (rstate == R_DATA) && rvalid && rready;
      r_step = next_addr(raddr, rlen, rsize, rburst);
      rnext  = rstate;
      case (rstate)
         R_IDLE:  if (ar_hs) rnext = R_DATA;
         R_DATA:  if (r_hs && rlast) rnext = R_IDLE;
         default: rnext = R_IDLE;
      endcase
   end

   // rdata is loaded from the array with the same edge as any write, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rstate  <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= '0;
         rlast   <= 1'b0;
         raddr   <= '0;
         rlen    <= '0;
         rcnt    <= '0;
         rsize   <= '0;
         rburst  <= '0;
         rerr    <= 1'b0;
      end else begin
         rstate  <= rnext;
         arready <= (rnext == R_IDLE);
         rvalid  <= (rnext == R_DATA);
         if (ar_hs) begin
            rid    <= arid;
            raddr  <= araddr;
            rlen   <= arlen;
            rsize  <= arsize;
            rburst <= arburst;
            rcnt   <= '0;
            rerr   <= proto_err(arlen, arsize, arburst);
            rresp  <= proto_err(arlen, arsize, arburst) ? SLVERR : OKAY;
            rlast  <= (arlen == 8'd0);
            rdata  <= proto_err(arlen, arsize, arburst) ? '0 : mem[word_idx(araddr)];
         end else if (r_hs && !rlast) begin
            raddr <= r_step;
            rcnt  <= rcnt + 8'd1;
            rlast <= ((rcnt + 8'd1) == rlen);
            rdata <= rerr ? '0 : mem[word_idx(r_step)];
         end
      end
   end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: expected read beats are queued when a read is issued
// and popped as the DUT returns them.
module tb_axi_slave_mem;

   localparam int IDW = 16;
   localparam int AW  = 64;
   localparam int BW  = 32;
   localparam int DW  = BW * 8;

   logic           clk, rst;
   logic [IDW-1:0] awid, arid, bid, rid;
   logic [AW-1:0]  awaddr, araddr;
   logic [7:0]     awlen, arlen;
   logic [2:0]     awsize, arsize;
   logic [1:0]     awburst, arburst, bresp, rresp;
   logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic           arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0]  wdata, rdata;
   logic [BW-1:0]  wstrb;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] sb [$];
   logic [DW-1:0] obs_data [$];
   logic [1:0]    obs_resp [$];
   logic          obs_last [$];
   logic [IDW-1:0] obs_id  [$];
   logic [DW-1:0] wbeats [16];
   logic [BW-1:0] wstrbs [16];

   axi_slave_mem #(
      .ID_WIDTH  (IDW),
      .ADDR_WIDTH(AW),
      .BYTE_WIDTH(BW),
      .MEM_WORDS (1024)
   ) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Drives one write burst from wbeats/wstrbs; wlast is raised on beat last_at.
   task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int last_at,
                              output logic [IDW-1:0] bid_o, output logic [1:0] bresp_o,
                              output bit ok);
      bit hs;
      int t;
      ok = 1;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      t = 0;
      do begin hs = awready; @(posedge clk); #1; t++; end while (!hs && t < 100);
      awvalid = 1'b0;
      if (!hs) ok = 0;
      for (int k = 0; k <= int'(len) && ok; k++) begin
         wdata = wbeats[k]; wstrb = wstrbs[k]; wlast = (k == last_at); wvalid = 1'b1;
         t = 0;
         do begin hs = wready; @(posedge clk); #1; t++; end while (!hs && t < 100);
         if (!hs) ok = 0;
      end
      wvalid = 1'b0; wlast = 1'b0;
      bready = 1'b1;
      t = 0;
      do begin
         hs = bvalid; bid_o = bid; bresp_o = bresp;
         @(posedge clk); #1; t++;
      end while (!hs && t < 100);
      bready = 1'b0;
      if (!hs) ok = 0;
   endtask

   // Issues one read with rready held high and records every returned beat.
   task automatic read_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output bit ok);
      bit hs, done;
      int t;
      obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      t = 0;
      do begin hs = arready; @(posedge clk); #1; t++; end while (!hs && t < 100);
      arvalid = 1'b0;
      rready = 1'b1;
      done = 0; t = 0;
      while (hs && !done && t < 200) begin
         if (rvalid) begin
            obs_data.push_back(rdata); obs_resp.push_back(rresp);
            obs_last.push_back(rlast); obs_id.push_back(rid);
            done = rlast;
         end
         @(posedge clk); #1; t++;
      end
      rready = 1'b0;
      ok = hs && done && (obs_data.size() == int'(len) + 1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || bid !== '0 || bresp !== '0 ||
          rid !== '0 || rdata !== '0 || rresp !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy/valid=%b bid=%h bresp=%b rid=%h rresp=%b rdata_nz=%b, want all 0",
                  {awready, wready, bvalid, arready, rvalid, rlast}, bid, bresp, rid, rresp, |rdata);
      end
      rst = 1'b0;
      vectors++;
      if ({awready, arready} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_first_cycle: got awready/arready=%b, want 00", {awready, arready});
      end
      @(posedge clk); #1;
      vectors++;
      if ({awready, arready} !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_second_cycle: got awready/arready=%b, want 11", {awready, arready});
      end
   endtask

   task automatic test_incr();
      logic [IDW-1:0] b_id;
      logic [1:0]     b_resp;
      logic [DW-1:0]  exp;
      bit ok;
      for (int k = 0; k < 4; k++) begin wbeats[k] = DW'(k); wstrbs[k] = '1; end
      write_burst(16'h1234, 64'h100, 8'd3, 3'd5, 2'b01, 3, b_id, b_resp, ok);
      vectors++;
      if (!ok || b_resp !== 2'b00 || b_id !== 16'h1234) begin
         miscompares++;
         $display("FAIL incr_write_b: got ok=%0d bid=%h bresp=%b, want ok=1 bid=1234 bresp=00", ok, b_id, b_resp);
      end
      for (int k = 0; k < 4; k++) sb.push_back(DW'(k));
      read_burst(16'h0bee, 64'h100, 8'd3, 3'd5, 2'b01, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL incr_read_count: got %0d beats, want 4", obs_data.size()); end
      for (int k = 0; k < 4; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (obs_data[k] !== exp || obs_resp[k] !== 2'b00 || obs_last[k] !== (k == 3) || obs_id[k] !== 16'h0bee) begin
            miscompares++;
            $display("FAIL incr_read_beat%0d: got data=%h resp=%b last=%b id=%h, want data=%h resp=00 last=%0d id=0bee",
                     k, obs_data[k], obs_resp[k], obs_last[k], obs_id[k], exp, (k == 3));
         end
      end
   endtask

   task automatic test_strobes();
      logic [IDW-1:0] b_id;
      logic [1:0]     b_resp0, b_resp1;
      logic [DW-1:0]  exp;
      bit ok0, ok1, ok;
      wbeats[0] = '1; wstrbs[0] = '1;
      write_burst(16'h0001, 64'h40, 8'd0, 3'd5, 2'b01, 0, b_id, b_resp0, ok0);
      wbeats[0] = {{28{8'h55}}, 32'hdeadbeef}; wstrbs[0] = 32'h0000000f;
      write_burst(16'h0002, 64'h40, 8'd0, 3'd5, 2'b01, 0, b_id, b_resp1, ok1);
      vectors++;
      if (!ok0 || !ok1 || b_resp0 !== 2'b00 || b_resp1 !== 2'b00) begin
         miscompares++;
         $display("FAIL strobe_write_b: got ok=%0d%0d bresp=%b/%b, want ok=11 bresp=00/00", ok0, ok1, b_resp0, b_resp1);
      end
      sb.push_back({{28{8'hff}}, 32'hdeadbeef});
      read_burst(16'h0003, 64'h40, 8'd0, 3'd5, 2'b01, ok);
      exp = sb.pop_front();
      vectors++;
      if (!ok || obs_data[0] !== exp || obs_last[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL strobe_readback: got ok=%0d data=%h last=%b, want data=%h last=1", ok, obs_data[0], obs_last[0], exp);
      end
   endtask

   task automatic test_wrap();
      logic [IDW-1:0] b_id;
      logic [1:0]     b_resp;
      logic [DW-1:0]  exp;
      bit ok;
      for (int k = 0; k < 4; k++) begin wbeats[k] = DW'(k + 1); wstrbs[k] = '1; end
      write_burst(16'h0010, 64'h1a0, 8'd3, 3'd5, 2'b10, 3, b_id, b_resp, ok);
      vectors++;
      if (!ok || b_resp !== 2'b00) begin
         miscompares++;
         $display("FAIL wrap_write_b: got ok=%0d bresp=%b, want ok=1 bresp=00", ok, b_resp);
      end
      sb.push_back(DW'(4)); sb.push_back(DW'(1)); sb.push_back(DW'(2)); sb.push_back(DW'(3));
      read_burst(16'h0011, 64'h180, 8'd3, 3'd5, 2'b01, ok);
      for (int k = 0; k < 4; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (!ok || obs_data[k] !== exp) begin
            miscompares++;
            $display("FAIL wrap_incr_read_beat%0d: got data=%h, want %h", k, obs_data[k], exp);
         end
      end
      for (int k = 1; k <= 4; k++) sb.push_back(DW'(k));
      read_burst(16'h0012, 64'h1a0, 8'd3, 3'd5, 2'b10, ok);
      for (int k = 0; k < 4; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (!ok || obs_data[k] !== exp || obs_last[k] !== (k == 3)) begin
            miscompares++;
            $display("FAIL wrap_read_beat%0d: got data=%h last=%b, want data=%h last=%0d", k, obs_data[k], obs_last[k], exp, (k == 3));
         end
      end
   endtask

   task automatic test_errors();
      logic [IDW-1:0] b_id;
      logic [1:0]     b_resp;
      logic [DW-1:0]  exp;
      bit ok;
      // reserved burst type: response is SLVERR and word 0x100 keeps its earlier value 0
      wbeats[0] = {8{32'hbad0bad0}}; wstrbs[0] = '1;
      write_burst(16'h0020, 64'h100, 8'd0, 3'd5, 2'b11, 0, b_id, b_resp, ok);
      vectors++;
      if (!ok || b_resp !== 2'b10 || b_id !== 16'h0020) begin
         miscompares++;
         $display("FAIL err_burst_b: got ok=%0d bid=%h bresp=%b, want ok=1 bid=0020 bresp=10", ok, b_id, b_resp);
      end
      sb.push_back('0);
      read_burst(16'h0021, 64'h100, 8'd0, 3'd5, 2'b01, ok);
      exp = sb.pop_front();
      vectors++;
      if (!ok || obs_data[0] !== exp || obs_resp[0] !== 2'b00) begin
         miscompares++;
         $display("FAIL err_burst_mem: got data=%h resp=%b, want data=%h resp=00", obs_data[0], obs_resp[0], exp);
      end
      // early wlast: burst still runs 4 beats and commits data
      for (int k = 0; k < 4; k++) begin wbeats[k] = {8{32'h11111111 * (k + 1)}}; wstrbs[k] = '1; end
      write_burst(16'h0022, 64'h200, 8'd3, 3'd5, 2'b01, 1, b_id, b_resp, ok);
      vectors++;
      if (!ok || b_resp !== 2'b10) begin
         miscompares++;
         $display("FAIL err_wlast_b: got ok=%0d bresp=%b, want ok=1 bresp=10", ok, b_resp);
      end
      for (int k = 0; k < 4; k++) sb.push_back({8{32'h11111111 * (k + 1)}});
      read_burst(16'h0023, 64'h200, 8'd3, 3'd5, 2'b01, ok);
      for (int k = 0; k < 4; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (!ok || obs_data[k] !== exp || obs_resp[k] !== 2'b00) begin
            miscompares++;
            $display("FAIL err_wlast_mem_beat%0d: got data=%h resp=%b, want data=%h resp=00", k, obs_data[k], obs_resp[k], exp);
         end
      end
      // oversize read: 4 beats of zero data with SLVERR
      for (int k = 0; k < 4; k++) sb.push_back('0);
      read_burst(16'h0024, 64'h100, 8'd3, 3'd6, 2'b01, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL err_size_count: got %0d beats, want 4", obs_data.size()); end
      for (int k = 0; k < 4; k++) begin
         exp = sb.pop_front();
         vectors++;
         if (obs_data[k] !== exp || obs_resp[k] !== 2'b10 || obs_last[k] !== (k == 3)) begin
            miscompares++;
            $display("FAIL err_size_beat%0d: got data=%h resp=%b last=%b, want data=0 resp=10 last=%0d",
                     k, obs_data[k], obs_resp[k], obs_last[k], (k == 3));
         end
      end
      // WRAP with len=2 is illegal
      read_burst(16'h0025, 64'h1a0, 8'd2, 3'd5, 2'b10, ok);
      vectors++;
      if (!ok || obs_resp[0] !== 2'b10 || obs_resp[2] !== 2'b10 || obs_data[1] !== '0) begin
         miscompares++;
         $display("FAIL err_wrap_len: got ok=%0d resp0=%b resp2=%b, want ok=1 resp=10 data=0", ok, obs_resp[0], obs_resp[2]);
      end
   endtask

   task automatic test_backpressure_reset();
      logic [IDW-1:0] b_id;
      logic [1:0]     b_resp;
      logic [DW-1:0]  exp, pd;
      logic [DW-1:0]  model [8];
      logic           pv, pl, pr;
      bit ok, hs;
      int got, t;
      for (int k = 0; k < 8; k++) begin model[k] = rand_word(); wbeats[k] = model[k]; wstrbs[k] = '1; end
      write_burst(16'h0030, 64'h400, 8'd7, 3'd5, 2'b01, 7, b_id, b_resp, ok);
      vectors++;
      if (!ok || b_resp !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_write_b: got ok=%0d bresp=%b, want ok=1 bresp=00", ok, b_resp);
      end
      for (int k = 0; k < 8; k++) sb.push_back(model[k]);
      arid = 16'h0031; araddr = 64'h400; arlen = 8'd7; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b1;
      t = 0;
      do begin hs = arready; @(posedge clk); #1; t++; end while (!hs && t < 100);
      arvalid = 1'b0;
      got = 0; t = 0;
      while (hs && got < 8 && t < 400) begin
         rready = 1'($urandom_range(0, 1));
         pv = rvalid; pd = rdata; pl = rlast; pr = rready;
         @(posedge clk); #1; t++;
         if (pv && pr) begin
            exp = sb.pop_front();
            vectors++;
            if (pd !== exp || pl !== (got == 7)) begin
               miscompares++;
               $display("FAIL bp_beat%0d: got data=%h last=%b, want data=%h last=%0d", got, pd, pl, exp, (got == 7));
            end
            got++;
         end else if (pv) begin
            vectors++;
            if (rvalid !== 1'b1 || rdata !== pd || rlast !== pl) begin
               miscompares++;
               $display("FAIL bp_stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                        rvalid, rdata, rlast, pd, pl);
            end
         end
      end
      rready = 1'b0;
      vectors++;
      if (got != 8) begin miscompares++; $display("FAIL bp_beat_count: got %0d, want 8", got); end

      // reset while beat 2 of a read is on the bus
      rready = 1'b1;
      arid = 16'h0032; arvalid = 1'b1;
      t = 0;
      do begin hs = arready; @(posedge clk); #1; t++; end while (!hs && t < 100);
      arvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (rvalid !== 1'b1 || rdata !== model[2]) begin
         miscompares++;
         $display("FAIL rst_pre_beat2: got valid=%b data=%h, want valid=1 data=%h", rvalid, rdata, model[2]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      vectors++;
      if ({rvalid, arready, awready, bvalid, wready} !== 5'b0) begin
         miscompares++;
         $display("FAIL rst_mid_valids: got rvalid/arready/awready/bvalid/wready=%b, want 00000",
                  {rvalid, arready, awready, bvalid, wready});
      end
      rst = 1'b0;
      vectors++;
      if (arready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_first_cycle: got arready=%b, want 0", arready); end
      @(posedge clk); #1;
      vectors++;
      if ({arready, awready} !== 2'b11) begin
         miscompares++;
         $display("FAIL rst_mid_second_cycle: got arready/awready=%b, want 11", {arready, awready});
      end
      sb.push_back(model[0]);
      read_burst(16'h0033, 64'h400, 8'd0, 3'd5, 2'b01, ok);
      exp = sb.pop_front();
      vectors++;
      if (!ok || obs_data[0] !== exp) begin
         miscompares++;
         $display("FAIL rst_mem_kept: got ok=%0d data=%h, want %h", ok, obs_data[0], exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      test_reset();
      test_incr();
      test_strobes();
      test_wrap();
      test_errors();
      test_backpressure_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
